// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous FIFO read port and sends each as a UART frame, LSB first.
// Optional feature macro FIFO_UART_TX_PARITY_EN inserts an even-parity bit between the data and stop bits.
module fifo_uart_tx #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        fifo_rd_q, fifo_rd_d;
    logic        tx_done_q, tx_done_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif
    logic        bit_end;
    logic        start_ok;

    assign bit_end  = (baud_q == BAUD_LAST);
    assign start_ok = enable && !fifo_empty;

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            fifo_rd_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            fifo_rd_q <= fifo_rd_d;
            tx_done_q <= tx_done_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_ok) state_d = S_FETCH;
            S_FETCH:  state_d = S_WAIT;
            S_WAIT:   state_d = S_START;
            S_START:  if (bit_end) state_d = S_DATA;
            S_DATA: begin
                if (bit_end && bit_idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP:   if (bit_end) state_d = start_ok ? S_FETCH : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_d = 1'b0;
        tx_done_d = 1'b0;
        tx_d      = tx_q;
        baud_d    = bit_end ? 16'd0 : baud_q + 16'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d    = '0;
                tx_d      = 1'b1;
                fifo_rd_d = start_ok;
            end
            S_FETCH: baud_d = '0;
            S_WAIT: begin
                // FIFO data_out is valid now, one cycle after the read strobe
                shift_d   = fifo_data;
                tx_d      = 1'b0;
                baud_d    = '0;
                bit_idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d  = ^fifo_data;
`endif
            end
            S_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_d = parity_q;
`else
                        tx_d = 1'b1;
`endif
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            S_PARITY: if (bit_end) tx_d = 1'b1;
            S_STOP: begin
                if (bit_end) begin
                    tx_done_d = 1'b1;
                    fifo_rd_d = start_ok;
                end
            end
            default: tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign fifo_rd = fifo_rd_q;
    assign tx_done = tx_done_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeds random and directed bytes; a UART receiver
// monitor pops the expected byte at each start bit and checks the whole frame shape.
module tb_fifo_uart_tx;
    localparam int D = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       tx_done;

    fifo_uart_tx #(.CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // FIFO model: unbounded storage, registered data_out
    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int total_push = 0;
    logic [7:0] exp_q[$];
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd) begin
            check("no_underflow", {31'd0, (wr_ptr != rd_ptr)}, 1);
            fifo_data <= mem[rd_ptr % 256];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 256] = b;
        exp_q.push_back(b);
        wr_ptr++;
        total_push++;
    endtask

    function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
        logic [NB-1:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef FIFO_UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    // Receiver / scoreboard monitor
    logic          in_frame = 1'b0;
    logic          tx_prev = 1'b1;
    logic          rd_prev = 1'b0;
    logic          chk_gap = 1'b0;
    logic          gap_valid = 1'b0;
    logic [7:0]    cur = '0;
    logic [7:0]    rx_byte = '0;
    logic          rx_par = 1'b0;
    logic [NB-1:0] exp_bits = '1;
    int cnt = 0, shape_err = 0, frames_done = 0;
    int rd_count = 0, rd_wide = 0, last_rd_cyc = 0, last_fall_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            tx_prev  = 1'b1;
            rd_prev  = 1'b0;
        end else begin
            if (fifo_rd) begin
                rd_count++;
                last_rd_cyc = cyc;
                if (rd_prev) rd_wide++;
            end
            rd_prev = fifo_rd;
            if (!in_frame && tx_prev && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    exp_bits = frame_bits(cur);
                    if (chk_gap && gap_valid) check("start_gap", cyc - last_fall_cyc, NB*D + 2);
                    gap_valid = chk_gap;
                    last_fall_cyc = cyc;
                    in_frame = 1'b1;
                    cnt = 0;
                    shape_err = 0;
                    rx_byte = '0;
                end
            end
            if (in_frame) begin
                if (cnt < NB*D) begin
                    if (tx !== exp_bits[cnt/D] || tx_done !== 1'b0 || busy !== 1'b1) shape_err++;
                    if (cnt % D == D/2 && cnt/D >= 1 && cnt/D <= 8) rx_byte[cnt/D-1] = tx;
                    if (cnt % D == D/2 && cnt/D == 9) rx_par = tx;
                    cnt++;
                end else begin
                    check("frame_data", {24'd0, rx_byte}, {24'd0, cur});
                    check("frame_shape", shape_err, 0);
                    check("tx_done_at_end", {31'd0, tx_done}, 1);
                    in_frame = 1'b0;
                    frames_done++;
                end
            end
            tx_prev = tx;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frames_done < target; i++) tick();
        check("frames_reached", frames_done, target);
    endtask

    task automatic wait_fall(input int budget);
        for (int i = 0; i < budget && !in_frame; i++) tick();
        check("start_seen", {31'd0, in_frame}, 1);
    endtask

    int push_cyc, rd0, target, busy_low, idle_bad, n;

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        repeat (3) begin
            tick();
            check("rst_tx", {31'd0, tx}, 1);
            check("rst_rd", {31'd0, fifo_rd}, 0);
            check("rst_busy", {31'd0, busy}, 0);
            check("rst_done", {31'd0, tx_done}, 0);
        end
        rst = 1'b0;
        idle_bad = 0;
        repeat (100) begin
            tick();
            if (tx !== 1'b1 || fifo_rd !== 1'b0 || busy !== 1'b0) idle_bad++;
        end
        check("idle_quiet", idle_bad, 0);
        check("idle_rd_count", rd_count, 0);

        // single byte and latency
        push(8'hA5);
        push_cyc = cyc;
        wait_frames(frames_done + 1, 200);
        check("rd_latency", last_rd_cyc - push_cyc, 1);
        check("start_latency", last_fall_cyc - push_cyc, 3);
        check("single_rd_count", rd_count, 1);

        // burst drain
        rd0 = rd_count;
        chk_gap = 1'b1;
        push(8'h00); push(8'hFF); push(8'h3C);
        target = frames_done + 3;
        busy_low = 0;
        for (int i = 0; i < 600 && frames_done < target; i++) begin
            tick();
            if (frames_done < target && busy !== 1'b1) busy_low++;
        end
        check("burst_frames", frames_done, target);
        check("burst_busy", busy_low, 0);
        check("burst_rd", rd_count - rd0, 3);
        check("burst_fifo_empty", wr_ptr - rd_ptr, 0);
        chk_gap = 1'b0;

        // enable drop mid-frame
        rd0 = rd_count;
        push(8'($urandom)); push(8'($urandom));
        target = frames_done + 1;
        wait_fall(100);
        repeat (3*D) tick();
        enable = 1'b0;
        wait_frames(target, 200);
        repeat (20) tick();
        check("drop_rd", rd_count - rd0, 1);
        check("drop_busy", {31'd0, busy}, 0);
        check("drop_fifo_left", wr_ptr - rd_ptr, 1);
        enable = 1'b1;
        wait_frames(target + 1, 200);
        check("reenable_rd", rd_count - rd0, 2);

        // reset during data bit 4 of 0x55
        push(8'h55); push(8'($urandom));
        target = frames_done + 1;
        wait_fall(100);
        repeat (5*D) tick();
        rst = 1'b1;
        tick();
        check("midrst_tx", {31'd0, tx}, 1);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_rd", {31'd0, fifo_rd}, 0);
        check("midrst_done", {31'd0, tx_done}, 0);
        rst = 1'b0;
        wait_frames(target, 300);
        check("midrst_fifo_empty", wr_ptr - rd_ptr, 0);

        // random bursts
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 6));
            target = frames_done + n;
            for (int k = 0; k < n; k++) begin
                push(8'($urandom));
                repeat ($urandom_range(0, 3)) tick();
            end
            wait_frames(target, n*100 + 100);
        end

`ifdef FIFO_UART_TX_PARITY_EN
        push(8'h07);
        wait_frames(frames_done + 1, 200);
        check("parity_bit", {31'd0, rx_par}, 1);
`endif

        repeat (10) tick();
        check("exp_queue_drained", exp_q.size(), 0);
        check("total_rd", rd_count, total_push);
        check("rd_single_cycle", rd_wide, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the team's 8-deep synchronous byte FIFO. It drains bytes via the FIFO's `rd`/`empty`/`data_out` port and serializes each one as an asynchronous 8N1 UART frame, LSB first. It sits between the FIFO's read port and the chip-level serial output pin.

## Interface
- `CLK_DIV`, default 16: clk cycles per serial bit; legal range 2..65535.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits starting a new frame; sampled only in IDLE and at STOP end.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  8  FIFO `data_out`; valid the cycle after a `fifo_rd` pulse.
- `fifo_rd`  out  1  registered read strobe to FIFO; single-cycle pulse per byte.
- `tx`  out  1  registered serial line; idles high.
- `busy`  out  1  high in every state except IDLE.
- `tx_done`  out  1  registered one-cycle pulse after the final stop-bit cycle.

## Operation
- States: IDLE, FETCH, WAIT, START, DATA, PARITY (only when the configuration macro is defined), STOP.
- IDLE: if `enable && !fifo_empty`, go to FETCH and set `fifo_rd` to 1. Otherwise stay.
- FETCH: lasts 1 cycle with `fifo_rd`=1. Clear `fifo_rd` and go to WAIT.
- WAIT: lasts 1 cycle. At the edge, capture `fifo_data` into the 8-bit shift register, drive `tx`=0, clear the baud counter, and go to START.
- START, DATA, PARITY, STOP: each bit lasts exactly `CLK_DIV` cycles.
  - Baud counter is 16-bit and counts 0..CLK_DIV-1.
  - DATA: the 3-bit bit index goes 0..7. `tx` = shift[0] and the register shifts right at each bit boundary.
- STOP: `tx`=1. At the last stop cycle, pulse `tx_done`. Then:
  - if `enable && !fifo_empty`, go directly to FETCH with `fifo_rd`=1;
  - else go to IDLE.
- Each popped byte is transmitted exactly once. `fifo_rd` is never asserted while `fifo_empty`=1, so no underflow is possible.
- `enable` deasserted mid-frame: the current frame completes and no new fetch is made.
- `fifo_empty` and `fifo_data` are ignored outside the points above.

## Timing
- Reset values: `tx`=1, `fifo_rd`=0, `busy`=0, `tx_done`=0. State = IDLE and all counters = 0.
- Reset mid-frame:
  - Outputs return to their reset values on the next edge.
  - A byte already popped is discarded.
  - A `fifo_rd` pulse in flight is dropped at that edge.
- Latency, from the IDLE edge that samples non-empty:
  - `fifo_rd` high at cycle 1;
  - `tx` falls at cycle 3 (after FETCH and WAIT);
  - first data bit at cycle 3+CLK_DIV.
- Frame length is 10×CLK_DIV cycles, or 11×CLK_DIV with parity.
- Back-to-back frames: `tx` stays high for exactly CLK_DIV + 2 cycles between start bits of consecutive frames (stop bit plus FETCH and WAIT).
- `busy` rises with `fifo_rd` and stays high across back-to-back frames. It falls on the edge entering IDLE.
- `tx_done` is coincident with the edge that leaves STOP.

## Configuration
- `FIFO_UART_TX_PARITY_EN` defined: the PARITY state is inserted between DATA and STOP.
  - Duration is CLK_DIV cycles.
  - `tx` = XOR of the 8 data bits (even parity).
  - Frame length is 11×CLK_DIV.
- Undefined: no PARITY state; the frame is 8N1 with length 10×CLK_DIV.

## Test plan
- Reset and idle: hold `rst` for 3 cycles with `fifo_empty`=1 and `enable`=1. Required: `tx`=1, `fifo_rd`=0, `busy`=0 throughout, and no `fifo_rd` for 100 cycles.
- Single byte: CLK_DIV=4, FIFO holds 0xA5. Required:
  - `fifo_rd` pulses once;
  - `tx` low 3 cycles later for 4 cycles;
  - then bits 1,0,1,0,0,1,0,1 at 4 cycles each;
  - then 4 high cycles and a `tx_done` pulse;
  - 40 cycles from start bit to `tx_done`.
- Burst drain: push 0x00, 0xFF, 0x3C into a FIFO of 8 entries. Required:
  - 3 frames in order;
  - exactly 6 high cycles between consecutive start-bit falls;
  - `busy` continuous;
  - FIFO count reaches 0;
  - exactly 3 `fifo_rd` pulses.
- Enable drop: deassert `enable` during DATA of frame 1 with 2 bytes queued. Required: frame 1 completes, no further `fifo_rd`, and `busy`=0. Re-enable and the second byte is sent.
- Reset mid-frame: assert `rst` during bit 4 of 0x55. Required: `tx`=1 on the next edge, the frame is abandoned, and the next byte in the FIFO is sent cleanly after release.
- Parity (macro defined): send 0x07 with CLK_DIV=4. Required: parity bit = 1, stop follows, frame length 44 cycles.
